// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle core: word RAM, a TX byte FIFO,
// a status register and a compare/match timer, all behind one load/store port.
module dmem_responder #(
    parameter int unsigned RAM_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        mem_write,
    output logic [31:0] rdata_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]    ram_q  [RAM_WORDS];
    logic [7:0]     fifo_q [FIFO_DEPTH];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [31:0]    tcmp_q, tcmp_d;
    logic [31:0]    tcnt_q, tcnt_d;
    logic           irq_q, irq_d;

    logic           ram_sel, reg_page, txd_sel, stat_sel, tcmp_sel, tcnt_sel;
    logic [AW-1:0]  ram_idx;
    logic           fifo_full, fifo_empty, push_req, push, pop, timer_match;
    logic [31:0]    count_ext;
    logic [2:0]     count_disp;
    logic [31:0]    status_word;
    logic           unused_addr_lsbs;

    // Address decode; the byte-offset bits never participate.
    assign ram_sel          = (addr_in[31:AW+2] == '0);
    assign ram_idx          = addr_in[AW+1:2];
    assign reg_page         = (addr_in[31:8] == 24'hFF_FFFF);
    assign txd_sel          = reg_page && (addr_in[7:2] == 6'd0);
    assign stat_sel         = reg_page && (addr_in[7:2] == 6'd1);
    assign tcmp_sel         = reg_page && (addr_in[7:2] == 6'd2);
    assign tcnt_sel         = reg_page && (addr_in[7:2] == 6'd3);
    assign unused_addr_lsbs = ^addr_in[1:0];

    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign push_req    = mem_write && txd_sel;
    assign push        = push_req && !fifo_full;
    assign pop         = !fifo_empty && tx_ready;
    assign timer_match = (tcmp_q != '0) && (tcnt_q == tcmp_q);

    assign count_ext   = 32'(count_q);
    assign count_disp  = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
    assign status_word = {25'd0, overflow_q, irq_q, count_disp, fifo_empty, fifo_full};

    assign tx_data   = fifo_q[rd_ptr_q];
    assign tx_valid  = !fifo_empty;
    assign timer_irq = irq_q;

    // FIFO bookkeeping: overflow reflects a push attempted against a full FIFO.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_req && fifo_full)   overflow_d = 1'b1;
        else if (mem_write && stat_sel) overflow_d = 1'b0;
    end

    // Timer: counts 0..TCMP, flags the match; a TCNT write wins over a match.
    always_comb begin
        tcmp_d = tcmp_q;
        tcnt_d = tcnt_q;
        irq_d  = irq_q;
        if (tcmp_q == '0) begin
            tcnt_d = '0;
        end else if (timer_match) begin
            tcnt_d = '0;
            irq_d  = 1'b1;
        end else begin
            tcnt_d = tcnt_q + 32'd1;
        end
        if (mem_write && tcmp_sel) begin
            tcmp_d = wdata_in;
            tcnt_d = '0;
        end
        if (mem_write && tcnt_sel) begin
            tcnt_d = '0;
            irq_d  = 1'b0;
        end
    end

    always_comb begin
        rdata_out = 32'd0;
        if (ram_sel)       rdata_out = ram_q[ram_idx];
        else if (stat_sel) rdata_out = status_word;
        else if (tcmp_sel) rdata_out = tcmp_q;
        else if (tcnt_sel) rdata_out = tcnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tcmp_q     <= '0;
            tcnt_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tcmp_q     <= tcmp_d;
            tcnt_q     <= tcnt_d;
            irq_q      <= irq_d;
        end
    end

    // Storage arrays are not reset; reset only blocks writes into them.
    always_ff @(posedge clk) begin
        if (mem_write && ram_sel && !rst) ram_q[ram_idx] <= wdata_in;
    end

    always_ff @(posedge clk) begin
        if (push && !rst) fifo_q[wr_ptr_q] <= wdata_in[7:0];
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios then random traffic, all
// checked every cycle against a queue/array reference model.
module tb_dmem_responder;

    localparam int unsigned FDEPTH    = 4;
    localparam logic [31:0] RAM_BYTES = 32'h0000_0400;
    localparam logic [31:0] A_TXD     = 32'hFFFF_FF00;
    localparam logic [31:0] A_STAT    = 32'hFFFF_FF04;
    localparam logic [31:0] A_TCMP    = 32'hFFFF_FF08;
    localparam logic [31:0] A_TCNT    = 32'hFFFF_FF0C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_in, wdata_in;
    logic        mem_write, tx_ready;
    logic [31:0] rdata_out;
    logic [7:0]  tx_data;
    logic        tx_valid, timer_irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_ram [256];
    logic [7:0]  m_q [$];
    logic        m_ovf, m_irq;
    logic [31:0] m_tcmp, m_tcnt;

    logic [31:0] last_rdata;
    logic [7:0]  last_tx_data;
    logic        last_tx_valid, last_irq;

    dmem_responder #(.RAM_WORDS(256), .FIFO_DEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in),
        .mem_write(mem_write), .rdata_out(rdata_out), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] wa;
        int          cnt;
        wa  = {a[31:2], 2'b00};
        cnt = m_q.size();
        if (a < RAM_BYTES) return m_ram[a[9:2]];
        if (wa == A_STAT)
            return {25'd0, m_ovf, m_irq, 3'((cnt > 7) ? 7 : cnt),
                    1'(cnt == 0), 1'(cnt == FDEPTH)};
        if (wa == A_TCMP) return m_tcmp;
        if (wa == A_TCNT) return m_tcnt;
        return 32'd0;
    endfunction

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic rdy, input logic r);
        logic [31:0] wa;
        bit          full, pop, match;
        if (r) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_irq  = 1'b0;
            m_tcnt = 32'd0;
            m_tcmp = 32'd0;
            return;
        end
        wa    = {a[31:2], 2'b00};
        full  = (m_q.size() == FDEPTH);
        pop   = (m_q.size() != 0) && rdy;
        match = (m_tcmp != 0) && (m_tcnt == m_tcmp);
        if (w && a < RAM_BYTES) m_ram[a[9:2]] = d;
        if (pop) void'(m_q.pop_front());
        if (w && wa == A_TXD) begin
            if (full) m_ovf = 1'b1;
            else      m_q.push_back(d[7:0]);
        end
        if (w && wa == A_STAT) m_ovf = 1'b0;
        // Period of TCMP+1 cycles expressed as a modulus; TCMP=0 pins it at 0.
        m_tcnt = 32'((64'(m_tcnt) + 64'd1) % (64'(m_tcmp) + 64'd1));
        if (match) m_irq = 1'b1;
        if (w && wa == A_TCMP) begin
            m_tcmp = d;
            m_tcnt = 32'd0;
        end
        if (w && wa == A_TCNT) begin
            m_tcnt = 32'd0;
            m_irq  = 1'b0;
        end
    endtask

    // One bus cycle: drive, check everything visible before the edge, advance.
    task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic r);
        rst = r; mem_write = w; addr_in = a; wdata_in = d; tx_ready = rdy;
        @(negedge clk);
        last_rdata    = rdata_out;
        last_tx_data  = tx_data;
        last_tx_valid = tx_valid;
        last_irq      = timer_irq;
        check("rdata", rdata_out, model_read(a));
        check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
        check("timer_irq", 32'(timer_irq), 32'(m_irq));
        @(posedge clk);
        model_step(w, a, d, rdy, r);
        #1;
    endtask

    initial begin
        logic [31:0] exp_cnt [7];
        logic        exp_irq [7];
        logic [31:0] a, d;
        logic        w, rdy, r;
        int          sel;

        rst = 1'b1; mem_write = 1'b0; addr_in = 32'd0; wdata_in = 32'd0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Reset state
        cyc(1'b0, A_STAT, 32'd0, 1'b0, 1'b0);
        check("reset_status", last_rdata, 32'h0000_0002);
        cyc(1'b0, A_TCMP, 32'd0, 1'b0, 1'b0);
        check("reset_tcmp", last_rdata, 32'd0);

        for (int i = 0; i < 256; i++) cyc(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);

        // RAM write/read, byte offset ignored, read-before-write
        cyc(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
        cyc(1'b0, 32'h10, 32'd0, 1'b0, 1'b0);
        check("ram_rd_10", last_rdata, 32'hDEAD_BEEF);
        cyc(1'b0, 32'h13, 32'd0, 1'b0, 1'b0);
        check("ram_rd_13", last_rdata, 32'hDEAD_BEEF);
        cyc(1'b1, 32'h10, 32'h1, 1'b0, 1'b0);
        check("ram_rd_during_wr", last_rdata, 32'hDEAD_BEEF);
        cyc(1'b0, 32'h10, 32'd0, 1'b0, 1'b0);
        check("ram_rd_after_wr", last_rdata, 32'h1);

        // FIFO fill past full, then drain
        for (int i = 0; i < 5; i++) cyc(1'b1, A_TXD, 32'(8'h41 + i), 1'b0, 1'b0);
        cyc(1'b0, A_STAT, 32'd0, 1'b0, 1'b0);
        check("status_full_ovf", last_rdata, 32'h51);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            check("drain_data", 32'(last_tx_data), 32'(8'h41 + i));
        end
        cyc(1'b0, A_STAT, 32'd0, 1'b1, 1'b0);
        check("drain_valid", 32'(last_tx_valid), 32'd0);
        check("status_drained", last_rdata, 32'h42);

        // Overflow clear, simultaneous push/pop
        cyc(1'b1, A_STAT, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, A_STAT, 32'd0, 1'b0, 1'b0);
        check("ovf_cleared", last_rdata, 32'h02);
        cyc(1'b1, A_TXD, 32'h60, 1'b0, 1'b0);
        cyc(1'b1, A_TXD, 32'h61, 1'b0, 1'b0);
        cyc(1'b1, A_TXD, 32'h55, 1'b1, 1'b0);
        check("pushpop_head_before", 32'(last_tx_data), 32'h60);
        cyc(1'b0, A_STAT, 32'd0, 1'b0, 1'b0);
        check("pushpop_count", last_rdata, 32'h08);
        check("pushpop_head_after", 32'(last_tx_data), 32'h61);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("pushpop_tail", 32'(last_tx_data), 32'h55);

        // Timer period TCMP+1, sticky irq, TCNT write beats a same-cycle match
        exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cyc(1'b1, A_TCMP, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, A_TCNT, 32'd0, 1'b0, 1'b0);
            check("tcnt_seq", last_rdata, exp_cnt[i]);
            check("irq_seq", 32'(last_irq), 32'(exp_irq[i]));
        end
        cyc(1'b1, A_TCNT, 32'd0, 1'b0, 1'b0);
        check("tcnt_at_match", last_rdata, 32'd3);
        cyc(1'b0, A_TCNT, 32'd0, 1'b0, 1'b0);
        check("tcnt_cleared", last_rdata, 32'd0);
        check("irq_cleared", 32'(last_irq), 32'd0);

        // Reset mid-traffic: FIFO 3 deep, TCMP 5, irq set
        for (int i = 0; i < 3; i++) cyc(1'b1, A_TXD, 32'(8'h70 + i), 1'b0, 1'b0);
        cyc(1'b1, A_TCMP, 32'd5, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, A_TCNT, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, A_STAT, 32'd0, 1'b0, 1'b0);
        check("pre_rst_status", last_rdata, 32'h2C);
        cyc(1'b1, A_TXD, 32'h99, 1'b1, 1'b1);
        cyc(1'b0, A_STAT, 32'd0, 1'b0, 1'b0);
        check("post_rst_status", last_rdata, 32'h02);
        check("post_rst_valid", 32'(last_tx_valid), 32'd0);
        check("post_rst_irq", 32'(last_irq), 32'd0);
        cyc(1'b0, A_TCMP, 32'd0, 1'b0, 1'b0);
        check("post_rst_tcmp", last_rdata, 32'd0);
        cyc(1'b0, 32'h10, 32'd0, 1'b0, 1'b0);
        check("post_rst_ram", last_rdata, 32'h1);

        // Unmapped and TXDATA reads, unmapped write aliasing nothing
        cyc(1'b1, 32'd0, 32'hA5A5_A5A5, 1'b0, 1'b0);
        cyc(1'b0, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        check("unmapped_rd", last_rdata, 32'd0);
        cyc(1'b0, A_TXD, 32'd0, 1'b0, 1'b0);
        check("txdata_rd", last_rdata, 32'd0);
        cyc(1'b1, 32'h8000_0000, 32'h1234_5678, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("unmapped_wr_ram0", last_rdata, 32'hA5A5_A5A5);
        cyc(1'b0, A_STAT, 32'd0, 1'b0, 1'b0);
        check("unmapped_wr_status", last_rdata, 32'h02);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            sel = int'($urandom_range(0, 15));
            w   = 1'($urandom_range(0, 1));
            d   = $urandom;
            if (sel <= 5)       a = 32'($urandom_range(0, 1023));
            else if (sel <= 8)  a = A_TXD  | 32'($urandom_range(0, 3));
            else if (sel == 9)  a = A_STAT | 32'($urandom_range(0, 3));
            else if (sel == 10) begin
                a = A_TCMP;
                d = 32'($urandom_range(0, 6));
                w = ($urandom_range(0, 3) == 0);
            end
            else if (sel == 11) a = A_TCNT | 32'($urandom_range(0, 3));
            else if (sel == 12) a = 32'h8000_0000 | 32'($urandom_range(0, 4095));
            else if (sel == 13) a = $urandom;
            else begin
                a = A_STAT;
                w = 1'b0;
            end
            rdy = ($urandom_range(0, 2) != 0);
            r   = ($urandom_range(0, 99) == 0);
            cyc(w, a, d, rdy, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: RAM_WORDS, 256, data RAM depth in 32-bit words; power of two.
REQ-002 Parameter: FIFO_DEPTH, 4, TX byte FIFO depth; power of two, 2..16.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: addr_in  input  32  byte address from the core's MEM stage (the core's addr_out).
REQ-006 Port: wdata_in  input  32  store data from the core (the core's data_out).
REQ-007 Port: mem_write  input  1  store strobe; 1 = write this cycle.
REQ-008 Port: rdata_out  output  32  load data returned to the core's data_in.
REQ-009 Port: tx_data  output  8  head byte of the TX FIFO.
REQ-010 Port: tx_valid  output  1  TX FIFO non-empty.
REQ-011 Port: tx_ready  input  1  sink accepts tx_data this cycle.
REQ-012 Port: timer_irq  output  1  sticky timer-match flag.

Function
REQ-013 Address map SHALL be: RAM at 0x0000_0000..(RAM_WORDS*4-1), indexed by addr_in[log2(RAM_WORDS)+1:2]; TXDATA 0xFFFF_FF00; STATUS 0xFFFF_FF04; TCMP 0xFFFF_FF08; TCNT 0xFFFF_FF0C; addr_in[1:0] ignored everywhere.
REQ-014 rdata_out SHALL be combinational from addr_in and current state (zero-latency load); core samples it in the same cycle.
REQ-015 RAM write SHALL occur at the rising edge when mem_write=1 and addr_in is in RAM range; full 32-bit word, no byte enables.
REQ-016 Read of the address being written in the same cycle SHALL return the old (pre-edge) contents.
REQ-017 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored; reads of TXDATA SHALL return 0.
REQ-018 Write to TXDATA SHALL push wdata_in[7:0] when FIFO not full (pre-edge state); when full, byte dropped and sticky overflow set, even if a pop occurs the same cycle.
REQ-019 Pop SHALL occur at the edge when tx_valid=1 and tx_ready=1; tx_data = head entry; tx_valid = (count != 0).
REQ-020 Simultaneous push and pop with 0 < count < FIFO_DEPTH SHALL leave count unchanged; push to empty FIFO SHALL appear on tx_data/tx_valid the next cycle.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-022 STATUS read SHALL return {zeros, overflow[6], timer_irq[5], count[4:2] (low bits of count, saturating display at 7), empty[1], full[0]}.
REQ-023 Any write to STATUS SHALL clear overflow; other STATUS bits unaffected.
REQ-024 TCMP read/write SHALL access a 32-bit compare register; a write SHALL also zero the counter.
REQ-025 Counter SHALL hold at 0 while TCMP=0; otherwise increment by 1 per cycle.
REQ-026 When counter == TCMP (TCMP != 0), next edge SHALL set timer_irq and load counter with 0 (period = TCMP+1 cycles).
REQ-027 TCNT read SHALL return the counter; any write to TCNT SHALL zero the counter and clear timer_irq, taking priority over a same-cycle match.
REQ-028 timer_irq SHALL remain set until cleared by REQ-027 or reset.

Reset
REQ-029 rst=1 at an edge SHALL clear FIFO pointers and count, overflow, timer_irq, counter and TCMP; tx_valid=0, timer_irq=0 the following cycle.
REQ-030 RAM contents SHALL NOT be altered by rst; rst SHALL take priority over any same-cycle write, push or pop, including mid-burst FIFO traffic.

Verification
REQ-031 Write 0xDEADBEEF to 0x10, then read 0x10 and 0x13 -> rdata_out=0xDEADBEEF both; same-cycle write 0x1 to 0x10 while reading it -> returns 0xDEADBEEF.
REQ-032 tx_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> STATUS=0x51 (overflow, count 4, full); raise tx_ready -> tx_data 0x41..0x44 on consecutive cycles, then tx_valid=0, STATUS=0x42.
REQ-033 FIFO at count=2, push 0x55 with tx_ready=1 same cycle -> count stays 2, head advances; write STATUS -> overflow cleared.
REQ-034 TCMP=3 -> counter 0,1,2,3,0; timer_irq rises on the edge after counter=3 and holds; write TCNT -> timer_irq=0, counter=0.
REQ-035 Assert rst with FIFO count=3, TCMP=5, irq=1 -> next cycle tx_valid=0, STATUS=0x02, TCMP reads 0, earlier RAM word still reads back.
REQ-036 Read 0x8000_0000 and TXDATA -> 0; write 0x8000_0000 -> no RAM or register changes.
